// File: rtl/hiscore_bridge_leaf_pkg.sv
// Shared types and helpers for the high-score bridge leaf.
// Holds the transfer state encoding, the default window base and
// big-endian byte-lane helpers used when splitting or assembling words.
package jailbreak;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } hs_state_e;

    localparam logic [31:0] HS_BASE_ADDR  = 32'h00200000;
    localparam int          HS_SIZE_BYTES = 1024;

    // Lane 0 is the most significant byte, lane 3 the least (big-endian).
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] result;
        case (lane)
            2'd0:    result = word[31:24];
            2'd1:    result = word[23:16];
            2'd2:    result = word[15:8];
            default: result = word[7:0];
        endcase
        return result;
    endfunction

    // Returns word with one big-endian lane replaced by data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [7:0] data);
        logic [31:0] result;
        result = word;
        case (lane)
            2'd0:    result[31:24] = data;
            2'd1:    result[23:16] = data;
            2'd2:    result[15:8]  = data;
            default: result[7:0]   = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/hiscore_bridge_leaf_if.sv
// Bundle of the bridge-side bus and the byte-wide high-score RAM port.
// The leaf uses the slave modport; the host/arbiter side uses master.
interface hiscore_bridge_leaf_if #(
    parameter int ADDR_W = 10
);

    logic [31:0]       bridge_addr;
    logic              bridge_wr;
    logic [31:0]       bridge_wr_data;
    logic              bridge_rd;

    logic              hs_selected;
    logic [31:0]       hs_rd_data;
    logic              hs_busy;
    logic              hs_drop;

    logic              ram_req;
    logic              ram_gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport master (
        output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        input  hs_selected, hs_rd_data, hs_busy, hs_drop,
        input  ram_req, ram_addr, ram_wr, ram_wdata,
        output ram_gnt, ram_rdata
    );

    modport slave (
        input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        output hs_selected, hs_rd_data, hs_busy, hs_drop,
        output ram_req, ram_addr, ram_wr, ram_wdata,
        input  ram_gnt, ram_rdata
    );

endinterface

// File: rtl/hiscore_bridge_leaf.sv
// Bridge leaf exposing the high-score byte RAM as a word window.
// Each bridge word access becomes four big-endian byte accesses on the
// shared RAM port; read bytes are assembled in a shadow word that only
// becomes visible on hs_rd_data once all four bytes have arrived.
module hiscore_bridge_leaf
    import jailbreak::*;
#(
    parameter logic [31:0] BASE_ADDR  = HS_BASE_ADDR,
    parameter int          SIZE_BYTES = HS_SIZE_BYTES,
    parameter int          ADDR_W     = $clog2(SIZE_BYTES)
) (
    input  logic                 clk_74a,
    input  logic                 reset_n,
    hiscore_bridge_leaf_if.slave bus
);

    hs_state_e         state;
    hs_state_e         state_next;

    logic [1:0]        byte_idx;
    logic [1:0]        byte_idx_next;
    logic [ADDR_W-1:0] base_q;
    logic              is_write_q;
    logic [31:0]       wdata_q;

    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_wr_q;
    logic [7:0]        ram_wdata_q;

    logic              rd_valid_q;
    logic [1:0]        rd_lane_q;
    logic [31:0]       shadow_q;
    logic [31:0]       shadow_next;
    logic [31:0]       rd_data_q;
    logic              drop_q;

    logic [31:0]       offset;
    logic              in_window;
    logic [ADDR_W-1:0] word_base;
    logic              strobe;
    logic              start;
    logic              grant;

    // Window decode; subtracting first keeps the upper bound free of overflow.
    assign offset        = bus.bridge_addr - BASE_ADDR;
    assign in_window     = (bus.bridge_addr >= BASE_ADDR) && (offset < 32'(SIZE_BYTES));
    assign word_base     = {offset[ADDR_W-1:2], 2'b00};

    assign strobe        = in_window && (bus.bridge_wr || bus.bridge_rd);
    assign start         = strobe && (state == IDLE);
    assign grant         = (state == XFER) && bus.ram_gnt;
    assign byte_idx_next = byte_idx + 2'd1;

    // State register.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: four granted bytes per word, reads spend one extra cycle draining.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (grant && (byte_idx == 2'd3)) begin
                    state_next = is_write_q ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the request and drive the registered RAM address/data, advancing only on grant.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx    <= 2'd0;
            base_q      <= '0;
            is_write_q  <= 1'b0;
            wdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else if (start) begin
            byte_idx    <= 2'd0;
            base_q      <= word_base;
            is_write_q  <= bus.bridge_wr;
            wdata_q     <= bus.bridge_wr ? bus.bridge_wr_data : 32'd0;
            ram_addr_q  <= word_base;
            ram_wr_q    <= bus.bridge_wr;
            ram_wdata_q <= bus.bridge_wr ? lane_byte(bus.bridge_wr_data, 2'd0) : 8'd0;
        end else if (grant) begin
            byte_idx    <= byte_idx_next;
            ram_addr_q  <= base_q | ADDR_W'(byte_idx_next);
            ram_wdata_q <= lane_byte(wdata_q, byte_idx_next);
        end
    end

    // Shadow word with the byte arriving this cycle folded into its lane.
    always_comb begin
        shadow_next = shadow_q;
        if (rd_valid_q) begin
            shadow_next = lane_merge(shadow_q, rd_lane_q, bus.ram_rdata);
        end
    end

    // Read capture pipeline: tag each read grant, store its byte next cycle, publish on DRAIN.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_lane_q  <= 2'd0;
            shadow_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= grant && !is_write_q;
            if (grant && !is_write_q) begin
                rd_lane_q <= byte_idx;
            end
            if (rd_valid_q) begin
                shadow_q <= shadow_next;
            end
            if (state == DRAIN) begin
                rd_data_q <= shadow_next;
            end
        end
    end

    // One-cycle pulse for an in-window strobe that arrives while a word is in flight.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= strobe && (state != IDLE);
        end
    end

    assign bus.hs_selected = in_window;
    assign bus.hs_rd_data  = rd_data_q;
    assign bus.hs_busy     = (state != IDLE);
    assign bus.hs_drop     = drop_q;
    assign bus.ram_req     = (state == XFER);
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wr      = ram_wr_q;
    assign bus.ram_wdata   = ram_wdata_q;

endmodule
